// File: rtl/mux_pkg.sv
// ---------------------------------------------------------------------------
// mux_pkg
// Shared definitions for the round-robin select generator that drives the
// 4:1 output multiplexer.
//   NUM_CH      number of requesters / mux inputs
//   SEL_W       width of the mux select
//   state_t     arbiter FSM states
//   idx2onehot  channel index -> one-hot grant vector
// ---------------------------------------------------------------------------
package mux_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [NUM_CH-1:0] idx2onehot(input logic [SEL_W-1:0] idx);
        logic [NUM_CH-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Scans req starting at ptr and wrapping
// modulo NUM_CH; the first set bit wins.
// Ports:
//   req    in   request vector
//   ptr    in   index where the scan starts (highest priority)
//   found  out  at least one request bit is set
//   idx    out  index of the winning request (ptr when nothing is found)
// ---------------------------------------------------------------------------
module rr_pick
    import mux_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic              found,
    output logic [SEL_W-1:0]  idx
);

    logic [SEL_W-1:0] w_cand;

    // Walk from the farthest offset back to ptr so the nearest set bit is the
    // last one written and therefore wins.
    always_comb begin
        found  = 1'b0;
        idx    = ptr;
        w_cand = ptr;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            w_cand = ptr + SEL_W'(k);
            if (req[w_cand]) begin
                found = 1'b1;
                idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux_rr_arbiter
// Round-robin select generator for the 4:1 output mux. Grants one requester
// at a time, bounds each grant to HOLD_MAX cycles and rotates priority past
// the releasing channel so no requester starves. en low puts the mux output
// in high impedance.
// Parameters:
//   HOLD_MAX  max consecutive cycles per grant (1..15)
//   CNT_W     hold-counter width, 2**CNT_W > HOLD_MAX
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   req    in   per-channel request, bit i -> mux input a/b/c/d
//   done   in   current grantee finished, releases the grant early
//   en     out  mux enable, high while a grant is active
//   se     out  mux select, index of the granted channel
//   gnt    out  one-hot grant, zero when en is low
//   busy   out  copy of en for status readback
// ---------------------------------------------------------------------------
module mux_rr_arbiter
    import mux_pkg::*;
#(
    parameter int HOLD_MAX = 4,
    parameter int CNT_W    = 4
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req,
    input  logic              done,
    output logic              en,
    output logic [SEL_W-1:0]  se,
    output logic [NUM_CH-1:0] gnt,
    output logic              busy
);

    state_t              r_state;
    logic [SEL_W-1:0]    r_ptr;
    logic [CNT_W-1:0]    r_cnt;
    logic [SEL_W-1:0]    r_se;
    logic                r_en;
    logic [NUM_CH-1:0]   r_gnt;

    state_t              w_state_nxt;
    logic [SEL_W-1:0]    w_ptr_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [SEL_W-1:0]    w_se_nxt;
    logic                w_en_nxt;
    logic [NUM_CH-1:0]   w_gnt_nxt;

    logic                w_release;
    logic [SEL_W-1:0]    w_pick_ptr;
    logic                w_found;
    logic [SEL_W-1:0]    w_idx;

    // done, a dropped request and hold expiry all collapse into one release.
    assign w_release = done | ~req[r_se] | (r_cnt == CNT_W'(HOLD_MAX));

    // One picker serves both cases: in IDLE the scan starts at ptr; in GRANT
    // it is only consulted on release, where the new ptr is se+1, so it is
    // fed that value directly rather than waiting for ptr to update.
    assign w_pick_ptr = (r_state == GRANT) ? (r_se + SEL_W'(1)) : r_ptr;

    rr_pick u_pick (
        .req   (req),
        .ptr   (w_pick_ptr),
        .found (w_found),
        .idx   (w_idx)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (w_release && !w_found) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output / datapath logic (next values of the registered outputs)
    always_comb begin
        w_ptr_nxt = r_ptr;
        w_cnt_nxt = r_cnt;
        w_se_nxt  = r_se;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_se_nxt  = w_idx;
                    w_cnt_nxt = CNT_W'(1);
                end
            end
            GRANT: begin
                if (!w_release) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end else begin
                    w_ptr_nxt = r_se + SEL_W'(1);
                    if (w_found) begin
                        w_se_nxt  = w_idx;
                        w_cnt_nxt = CNT_W'(1);
                    end else begin
                        w_cnt_nxt = '0;
                    end
                end
            end
            default: begin
                w_cnt_nxt = '0;
            end
        endcase
        w_en_nxt  = (w_state_nxt == GRANT);
        w_gnt_nxt = w_en_nxt ? idx2onehot(w_se_nxt) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
            r_cnt <= '0;
            r_se  <= '0;
            r_en  <= 1'b0;
            r_gnt <= '0;
        end else begin
            r_ptr <= w_ptr_nxt;
            r_cnt <= w_cnt_nxt;
            r_se  <= w_se_nxt;
            r_en  <= w_en_nxt;
            r_gnt <= w_gnt_nxt;
        end
    end

    assign en   = r_en;
    assign se   = r_se;
    assign gnt  = r_gnt;
    assign busy = r_en;

endmodule
